mon_fifo_reader: RTL and testbench
==================================

// Module: mon_fifo_reader
// PURPOSE
//  Read-side controller of the monitoring FIFO. It drains the MonMem word store, which has a
//  registered read (data is valid one clk after the address is sampled), and presents words on a
//  valid/ready stream with no bubbles.
//  It owns the read pointer and returns it to the write-side logic for full detection.
//  It sits between MonMem and the monitoring frame builder in the EOC.
// PARAMETERS
//  DataWidth  16  width of one monitoring word
//  AddrWidth  5   MonMem address width; FIFO depth = 2**AddrWidth
// PORTS
//  clk       in   1             system clock; all logic on posedge
//  Reset_b   in   1             asynchronous, active-low reset
//  WrPtr     in   AddrWidth+1   write pointer from the writer (MSB = wrap bit), same clk domain
//  RdPtr     out  AddrWidth+1   read pointer to the writer (MSB = wrap bit)
//  RdAddr    out  AddrWidth     MonMem read address; equals RdPtr[AddrWidth-1:0]
//  MemData   in   DataWidth     MonMem OutData; holds mem[RdAddr] as sampled at the previous edge
//  Clear     in   1             synchronous flush; drops all unread words
//  OutData   out  DataWidth     stream data; head of the skid buffer
//  OutValid  out  1             OutData is valid
//  OutReady  in   1             consumer accepts; pop happens when OutValid & OutReady
//  Empty     out  1             no word in memory, in flight or buffered
//  Level     out  AddrWidth+2   total unread words: memory + in flight + buffered
// BEHAVIOUR
//  - Reset values: RdPtr=0, InFlight=0, BufCount=0, OutValid=0, OutData=0, Empty=1, Level=0.
//  - MemEmpty = (RdPtr == WrPtr). MemFull, which is computed by the writer, is RdPtr^WrPtr == {1,0..0}.
//  - Pointer arithmetic is modulo 2**(AddrWidth+1). Wrap-around needs no special case.
//  - Issue: Issue = !MemEmpty & !Clear & (BufCount + InFlight - Pop < 2).
//    - On Issue at edge k, MonMem samples RdAddr, and RdPtr increments.
//    - InFlight is set to 1 after edge k.
//  - Return: if InFlight=1 during the cycle after edge k, MemData is written into the buffer at
//    edge k+1. InFlight then clears, unless a new Issue occurs at the same edge.
//  - Skid buffer: 2 entries, FIFO order, with BufCount in 0..2.
//    - OutValid = (BufCount != 0).
//    - Pop and return may happen at the same edge. BufCount then changes by (+ret - pop).
//    - The issue credit guarantees that BufCount + InFlight <= 2 at all times. A return never
//      overflows the buffer.
//  - Latency: a word written to an empty FIFO (WrPtr increments at edge n) is issued at n+1 and
//    buffered at n+2. OutValid=1 after edge n+2. Minimum latency is 2 clk.
//  - Throughput: with OutReady held at 1 and a non-empty FIFO, there is one word per clk.
//  - Write/read same slot: the writer updates the memory and WrPtr at the same edge. The reader
//    only issues at a slot after WrPtr has passed it, so the data read is always the new word.
//  - A freed slot may be rewritten as soon as RdPtr passes it, because the data is already latched
//    in MonMem OutData.
//  - OutData/OutValid stability: while OutValid=1 and OutReady=0, OutData stays unchanged.
//  - Clear, effective at the next edge:
//    - RdPtr <= WrPtr; BufCount <= 0; InFlight <= 0; no issue occurs.
//    - Any return arriving at that edge is discarded.
//    - OutValid=0 after the edge; Pop is ignored in the Clear cycle.
//  - Level = (WrPtr - RdPtr) + InFlight + BufCount, combinational from registers.
//    Empty = (Level == 0).
//  - Reset asserted mid-transfer: all state returns to reset values at once, with no partial
//    words emitted.
//  - Simultaneous Clear and Reset_b=0: reset dominates.
// TESTING
//  1. Reset, WrPtr=0 -> RdPtr=0, OutValid=0, Empty=1, Level=0.
//  2. Write 0xA5A5 to slot 0 (WrPtr 0->1 at edge n), OutReady=1 -> OutValid=1 with OutData=0xA5A5
//     after edge n+2. Pop at edge n+3 -> Empty=1.
//  3. Preload 32 words 0..31 (WrPtr=32, i.e. wrap bit set, RdPtr=0), OutReady=1 -> 32 consecutive
//     beats 0..31, with no OutValid gaps after the first.
//  4. Fill 4 words, OutReady=0 -> exactly 2 issued; RdPtr=2, BufCount=2, Level=4.
//     OutData stays word0 until OutReady=1.
//  5. Wrap-around: RdPtr=WrPtr=30, write 4 words (WrPtr=34 mod 64) -> words are read from slots
//     30,31,0,1 in order, and RdPtr ends at 34.
//  6. Clear with InFlight=1 and BufCount=1 -> after the edge, OutValid=0, Level=0, RdPtr=WrPtr,
//     and the stale word never appears.
//     Reset_b pulse mid-stream -> outputs take reset values asynchronously.

Source files
------------

// File: rtl/mon_fifo_reader.sv
// -----------------------------------------------------------------------------
// mon_fifo_reader
//
// Read-side controller of the monitoring FIFO. It drains the MonMem word store,
// whose read port is registered (data appears one clk after the address is
// sampled). The words come out on a valid/ready stream that has no bubbles.
// The block owns the read pointer and hands it back to the write side, which
// uses it for full detection.
//
// A 2-entry skid buffer absorbs the one-cycle memory latency. A read is issued
// only when the words in flight plus the words buffered (after this cycle's pop)
// number fewer than two. This rule keeps the skid buffer from overflowing, and
// with OutReady held high it still gives one word per clk.
//
// Ports
//   clk       system clock, all logic on posedge
//   Reset_b   asynchronous active-low reset
//   WrPtr     write pointer from the writer (MSB = wrap bit)
//   RdPtr     read pointer to the writer (MSB = wrap bit)
//   RdAddr    MonMem read address (RdPtr without wrap bit)
//   MemData   MonMem OutData, holds mem[RdAddr] sampled at the previous edge
//   Clear     synchronous flush of all unread words
//   OutData   stream data (head of skid buffer)
//   OutValid  stream valid
//   OutReady  stream ready; pop when OutValid & OutReady
//   Empty     nothing in memory, in flight or buffered
//   Level     unread words: memory + in flight + buffered
// -----------------------------------------------------------------------------
module mon_fifo_reader #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 5
) (
  input  logic                 clk,
  input  logic                 Reset_b,
  input  logic [AddrWidth:0]   WrPtr,
  output logic [AddrWidth:0]   RdPtr,
  output logic [AddrWidth-1:0] RdAddr,
  input  logic [DataWidth-1:0] MemData,
  input  logic                 Clear,
  output logic [DataWidth-1:0] OutData,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic                 Empty,
  output logic [AddrWidth+1:0] Level
);

  // State
  logic [AddrWidth:0]   rd_ptr_q, rd_ptr_d;
  logic                 in_flight_q, in_flight_d;   // a MonMem read is returning this cycle
  logic [1:0]           buf_count_q, buf_count_d;   // skid buffer occupancy, 0..2
  logic [DataWidth-1:0] buf_q [2];                  // buf_q[0] is the stream head
  logic [DataWidth-1:0] buf_d [2];

  // Per-cycle control
  logic                 mem_empty;
  logic                 pop;
  logic                 ret;
  logic                 issue;
  logic [2:0]           occupancy;
  logic [1:0]           slot_after_pop;
  logic                 wr_sel;
  logic [AddrWidth:0]   mem_words;

  // NOTE: every signal assigned in this block gets a default value first. If a
  // branch left one unassigned, synthesis would infer a latch.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    in_flight_d = in_flight_q;
    buf_count_d = buf_count_q;
    buf_d       = buf_q;

    mem_empty = (rd_ptr_q == WrPtr);

    // Clear wins over the consumer: nothing pops in the flush cycle.
    pop = (buf_count_q != 2'd0) && OutReady && !Clear;

    // Data returning from MonMem is dropped when Clear is asserted.
    ret = in_flight_q && !Clear;

    // Issue credit: words in flight plus words buffered, minus this cycle's
    // pop, must stay below 2. Written as occ < 2 + pop to avoid an underflow.
    occupancy = {1'b0, buf_count_q} + {2'b00, in_flight_q};
    issue     = !mem_empty && !Clear && (occupancy < (3'd2 + {2'b00, pop}));

    // A returning word goes into the first free slot after this cycle's pop.
    slot_after_pop = buf_count_q - {1'b0, pop};
    wr_sel         = (slot_after_pop != 2'd0);

    if (Clear) begin
      rd_ptr_d    = WrPtr;
      in_flight_d = 1'b0;
      buf_count_d = 2'd0;
    end else begin
      if (issue) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      in_flight_d = issue;

      if (pop) begin
        buf_d[0] = buf_q[1];
      end
      if (ret) begin
        buf_d[wr_sel] = MemData;
      end
      buf_count_d = buf_count_q + {1'b0, ret} - {1'b0, pop};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together from pre-edge values, so simulation matches the hardware.
  always_ff @(posedge clk or negedge Reset_b) begin
    if (!Reset_b) begin
      rd_ptr_q    <= '0;
      in_flight_q <= 1'b0;
      buf_count_q <= 2'd0;
      // NOTE: this small data store is reset on purpose. OutData is a direct
      // view of buf_q[0] and must read 0 after reset. Large RAMs are normally
      // left without a reset.
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      in_flight_q <= in_flight_d;
      buf_count_q <= buf_count_d;
      buf_q[0]    <= buf_d[0];
      buf_q[1]    <= buf_d[1];
    end
  end

  // Outputs, all decoded directly from registers
  always_comb begin
    mem_words = WrPtr - rd_ptr_q;   // modulo 2**(AddrWidth+1), handles wrap
    RdPtr     = rd_ptr_q;
    RdAddr    = rd_ptr_q[AddrWidth-1:0];
    OutData   = buf_q[0];
    OutValid  = (buf_count_q != 2'd0);
    Level     = (AddrWidth+2)'(mem_words)
              + (AddrWidth+2)'(in_flight_q)
              + (AddrWidth+2)'(buf_count_q);
    Empty     = (Level == '0);
  end

  // Design invariants
  a_credit : assert property (@(posedge clk) disable iff (!Reset_b)
    (({1'b0, buf_count_q} + {2'b00, in_flight_q}) <= 3'd2));

  a_stable : assert property (@(posedge clk) disable iff (!Reset_b)
    (OutValid && !OutReady && !Clear) |=> (OutValid && $stable(OutData)));

endmodule

// File: tb/tb_mon_fifo_reader.sv
module tb_mon_fifo_reader;

  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk;
  logic          rst_b;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] mem_data;
  logic          clear;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          empty;
  logic [AW+1:0] level;

  int checks = 0;
  int errors = 0;

  // MonMem model: registered read of the address sampled at each edge
  logic [DW-1:0] mem [32];

  mon_fifo_reader #(.DataWidth(DW), .AddrWidth(AW)) dut (
    .clk      (clk),
    .Reset_b  (rst_b),
    .WrPtr    (wr_ptr),
    .RdPtr    (rd_ptr),
    .RdAddr   (rd_addr),
    .MemData  (mem_data),
    .Clear    (clear),
    .OutData  (out_data),
    .OutValid (out_valid),
    .OutReady (out_ready),
    .Empty    (empty),
    .Level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[rd_addr];

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b     = 1'b0;
    wr_ptr    = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    rst_b = 1'b1;
    tick();
  endtask

  // Bounded wait for OutValid; an expired bound counts as a failure
  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout out_valid=%b after %0d cycles", name, out_valid, n);
    end
  endtask

  task automatic test_reset();
    rst_b     = 1'b0;
    wr_ptr    = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++; if (rd_ptr !== 6'd0)     begin errors++; $display("FAIL reset_rd_ptr got %0d exp 0", rd_ptr); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (level !== 7'd0)      begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (out_data !== 16'h0)  begin errors++; $display("FAIL reset_out_data got %h exp 0000", out_data); end
    repeat (2) tick();
    rst_b = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    // edge n: writer stores word in slot 0 and bumps WrPtr
    mem[0] = 16'hA5A5;
    wr_ptr = 6'd1;
    #1;
    checks++; if (level !== 7'd1)     begin errors++; $display("FAIL single_level_n got %0d exp 1", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_n got %b exp 0", out_valid); end
    tick(); // n+1: issued
    checks++; if (rd_ptr !== 6'd1)    begin errors++; $display("FAIL single_rd_ptr_n1 got %0d exp 1", rd_ptr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_n1 got %b exp 0", out_valid); end
    checks++; if (level !== 7'd1)     begin errors++; $display("FAIL single_level_n1 got %0d exp 1", level); end
    tick(); // n+2: buffered
    checks++; if (out_valid !== 1'b1)    begin errors++; $display("FAIL single_valid_n2 got %b exp 1", out_valid); end
    checks++; if (out_data !== 16'hA5A5) begin errors++; $display("FAIL single_data_n2 got %h exp a5a5", out_data); end
    tick(); // n+3: popped
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL single_empty_n3 got %b exp 1", empty); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_n3 got %b exp 0", out_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 32; i++) mem[i] = 16'(i);
    wr_ptr    = 6'd32;
    out_ready = 1'b1;
    #1;
    checks++; if (level !== 7'd32) begin errors++; $display("FAIL stream_level_full got %0d exp 32", level); end
    wait_valid("stream");
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(i)) begin
        errors++;
        $display("FAIL stream_beat%0d got valid=%b data=%h exp valid=1 data=%h", i, out_valid, out_data, 16'(i));
      end
      tick();
    end
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL stream_empty got %b exp 1", empty); end
    checks++; if (rd_ptr !== 6'd32) begin errors++; $display("FAIL stream_rd_ptr got %0d exp 32", rd_ptr); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = 16'(16'h100 + i);
    wr_ptr = 6'd4;
    repeat (5) tick();
    checks++; if (rd_ptr !== 6'd2)       begin errors++; $display("FAIL bp_rd_ptr got %0d exp 2", rd_ptr); end
    checks++; if (level !== 7'd4)        begin errors++; $display("FAIL bp_level got %0d exp 4", level); end
    checks++; if (out_valid !== 1'b1)    begin errors++; $display("FAIL bp_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 16'h100)  begin errors++; $display("FAIL bp_head got %h exp 0100", out_data); end
    repeat (3) tick();
    checks++; if (out_data !== 16'h100)  begin errors++; $display("FAIL bp_head_hold got %h exp 0100", out_data); end
    checks++; if (rd_ptr !== 6'd2)       begin errors++; $display("FAIL bp_rd_ptr_hold got %0d exp 2", rd_ptr); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(16'h100 + i)) begin
        errors++;
        $display("FAIL bp_beat%0d got valid=%b data=%h exp valid=1 data=%h", i, out_valid, out_data, 16'(16'h100 + i));
      end
      tick();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bp_empty got %b exp 1", empty); end
  endtask

  task automatic test_wrap();
    do_reset();
    // Move both pointers to 30 by flushing
    wr_ptr = 6'd30;
    clear  = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (rd_ptr !== 6'd30) begin errors++; $display("FAIL wrap_rd_ptr_start got %0d exp 30", rd_ptr); end
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL wrap_empty_start got %b exp 1", empty); end
    mem[30] = 16'h0300;
    mem[31] = 16'h0301;
    mem[0]  = 16'h0302;
    mem[1]  = 16'h0303;
    wr_ptr    = 6'd34;
    out_ready = 1'b1;
    wait_valid("wrap");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(16'h300 + i)) begin
        errors++;
        $display("FAIL wrap_beat%0d got valid=%b data=%h exp valid=1 data=%h", i, out_valid, out_data, 16'(16'h300 + i));
      end
      tick();
    end
    checks++; if (rd_ptr !== 6'd34) begin errors++; $display("FAIL wrap_rd_ptr_end got %0d exp 34", rd_ptr); end
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL wrap_empty_end got %b exp 1", empty); end
  endtask

  task automatic test_clear();
    do_reset();
    mem[0] = 16'h0500;
    mem[1] = 16'h0501;
    mem[2] = 16'h0502;
    wr_ptr = 6'd3;
    repeat (2) tick(); // one word buffered, one in flight
    checks++; if (level !== 7'd3)  begin errors++; $display("FAIL clear_level_pre got %0d exp 3", level); end
    checks++; if (rd_ptr !== 6'd2) begin errors++; $display("FAIL clear_rd_ptr_pre got %0d exp 2", rd_ptr); end
    clear     = 1'b1;
    out_ready = 1'b1; // pop must be ignored in the Clear cycle
    tick();
    clear = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_valid got %b exp 0", out_valid); end
    checks++; if (level !== 7'd0)     begin errors++; $display("FAIL clear_level got %0d exp 0", level); end
    checks++; if (rd_ptr !== 6'd3)    begin errors++; $display("FAIL clear_rd_ptr got %0d exp 3", rd_ptr); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL clear_stale%0d got valid=%b data=%h exp valid=0", i, out_valid, out_data);
      end
    end
    mem[3] = 16'h5AA5;
    wr_ptr = 6'd4;
    wait_valid("clear_fresh");
    checks++; if (out_data !== 16'h5AA5) begin errors++; $display("FAIL clear_fresh_data got %h exp 5aa5", out_data); end
    tick();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = 16'(16'h700 + i);
    wr_ptr    = 6'd8;
    out_ready = 1'b1;
    repeat (4) tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_valid_pre got %b exp 1", out_valid); end
    #2;
    rst_b  = 1'b0; // asynchronous, between edges
    wr_ptr = 6'd0;
    #1;
    checks++; if (rd_ptr !== 6'd0)    begin errors++; $display("FAIL rmid_rd_ptr got %0d exp 0", rd_ptr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rmid_data got %h exp 0000", out_data); end
    checks++; if (level !== 7'd0)     begin errors++; $display("FAIL rmid_level got %0d exp 0", level); end
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL rmid_empty got %b exp 1", empty); end
    // Clear together with reset: reset dominates
    clear = 1'b1;
    tick();
    checks++; if (rd_ptr !== 6'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_clear got rd_ptr=%0d valid=%b exp 0 0", rd_ptr, out_valid);
    end
    clear = 1'b0;
    rst_b = 1'b1;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_after got %b exp 0", out_valid); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_wrap();
    test_clear();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
